// File: rtl/sht40_measure_sequencer.sv
// sht40_measure_sequencer
//   Drives an I2C master through complete SHT40 measurements: write the measure
//   command, wait out the conversion, read six bytes, split them into temperature
//   and humidity words, and publish the words when their checks pass. The
//   sequencer retries after a NACK, a short read or a CRC mismatch, and gives up
//   with an error pulse once the retries are used up.
//   Optional feature macro: SHT40_CRC_CHECK_EN. When it is defined, each word is
//   checked against its CRC-8 byte. When it is not defined, the CRC bytes are
//   consumed and dropped, crc_err stays 0, and the check always passes.
module sht40_measure_sequencer #(
    parameter logic [6:0]  DEV_ADDR      = 7'h44,
    parameter logic [7:0]  MEAS_CMD      = 8'hFD,
    parameter int unsigned MEAS_WAIT_CYC = 100000,
    parameter int unsigned RETRY_MAX     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] temp_raw,
    output logic [15:0] hum_raw,
    output logic        crc_err,
    output logic        i2c_req,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_cmd,
    output logic        i2c_writes,
    output logic [3:0]  i2c_reads,
    input  logic        i2c_byte_vld,
    input  logic [7:0]  i2c_byte,
    input  logic        i2c_done,
    input  logic        i2c_nack
);

    localparam int TW = $clog2(MEAS_WAIT_CYC + 1);
    localparam logic [TW-1:0] T_TERM = TW'(MEAS_WAIT_CYC - 1);
    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [RW-1:0] R_MAX  = RW'(RETRY_MAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD_REQ  = 3'd1,
        CMD_WAIT = 3'd2,
        CONV     = 3'd3,
        RD_REQ   = 3'd4,
        RD_WAIT  = 3'd5,
        CHECK    = 3'd6,
        RETRY    = 3'd7
    } state_t;

    state_t          state_r;
    logic [TW-1:0]   timer_r;
    logic [2:0]      idx_r;
    logic [RW-1:0]   retry_r;
    logic [15:0]     temp_buf_r;
    logic [15:0]     hum_buf_r;
    logic            byte_take_s;
    logic [2:0]      idx_nx_s;
    logic            crc_ok_s;

    // The device address and the command byte never change.
    assign i2c_addr = DEV_ADDR;
    assign i2c_cmd  = MEAS_CMD;

    // A byte is accepted only while fewer than six bytes are held. Extra bytes are dropped.
    assign byte_take_s = i2c_byte_vld && (idx_r != 3'd6);

    // This is the index after this cycle's byte, if any, is stored. The end-of-transfer test looks at this value.
    always_comb begin
        idx_nx_s = idx_r;
        if (byte_take_s) begin
            idx_nx_s = idx_r + 3'd1;
        end else begin
            idx_nx_s = idx_r;
        end
    end

`ifdef SHT40_CRC_CHECK_EN
    logic [7:0] tcrc_r;
    logic [7:0] hcrc_r;
    logic       crc_err_r;

    // Sensirion CRC-8: polynomial 0x31, init 0xFF, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_word(input logic [15:0] data);
        logic [7:0] crc;
        crc = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (crc[7] ^ data[i]) begin
                crc = {crc[6:0], 1'b0} ^ 8'h31;
            end else begin
                crc = {crc[6:0], 1'b0};
            end
        end
        return crc;
    endfunction

    // The check passes only when both words match their CRC bytes.
    always_comb begin
        crc_ok_s = (crc8_word(temp_buf_r) == tcrc_r) && (crc8_word(hum_buf_r) == hcrc_r);
    end

    assign crc_err = crc_err_r;
`else
    assign crc_ok_s = 1'b1;
    assign crc_err  = 1'b0;
`endif

    // Measurement sequencer. It holds all state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            i2c_req    <= 1'b0;
            i2c_writes <= 1'b0;
            i2c_reads  <= 4'd0;
            temp_raw   <= 16'h0000;
            hum_raw    <= 16'h0000;
            timer_r    <= {TW{1'b0}};
            idx_r      <= 3'd0;
            retry_r    <= {RW{1'b0}};
            temp_buf_r <= 16'h0000;
            hum_buf_r  <= 16'h0000;
`ifdef SHT40_CRC_CHECK_EN
            tcrc_r     <= 8'h00;
            hcrc_r     <= 8'h00;
            crc_err_r  <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            i2c_req <= 1'b0;
`ifdef SHT40_CRC_CHECK_EN
            crc_err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        retry_r    <= {RW{1'b0}};
                        i2c_req    <= 1'b1;
                        i2c_writes <= 1'b1;
                        i2c_reads  <= 4'd0;
                        state_r    <= CMD_REQ;
                    end
                end
                CMD_REQ: begin
                    state_r <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (i2c_nack) begin
                        state_r <= RETRY;
                    end else if (i2c_done) begin
                        timer_r <= {TW{1'b0}};
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    if (timer_r == T_TERM) begin
                        i2c_req    <= 1'b1;
                        i2c_writes <= 1'b0;
                        i2c_reads  <= 4'd6;
                        idx_r      <= 3'd0;
                        state_r    <= RD_REQ;
                    end else if (timer_r != T_SAT) begin
                        timer_r <= timer_r + {{(TW-1){1'b0}}, 1'b1};
                    end
                end
                RD_REQ: begin
                    state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (byte_take_s) begin
                        case (idx_r)
                            3'd0:    temp_buf_r[15:8] <= i2c_byte;
                            3'd1:    temp_buf_r[7:0]  <= i2c_byte;
                            3'd3:    hum_buf_r[15:8]  <= i2c_byte;
                            3'd4:    hum_buf_r[7:0]   <= i2c_byte;
`ifdef SHT40_CRC_CHECK_EN
                            3'd2:    tcrc_r           <= i2c_byte;
                            3'd5:    hcrc_r           <= i2c_byte;
`endif
                            default: ;
                        endcase
                    end
                    idx_r <= idx_nx_s;
                    if (i2c_nack) begin
                        state_r <= RETRY;
                    end else if (i2c_done) begin
                        state_r <= (idx_nx_s == 3'd6) ? CHECK : RETRY;
                    end
                end
                CHECK: begin
                    if (crc_ok_s) begin
                        temp_raw <= temp_buf_r;
                        hum_raw  <= hum_buf_r;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
`ifdef SHT40_CRC_CHECK_EN
                        crc_err_r <= 1'b1;
`endif
                        state_r <= RETRY;
                    end
                end
                RETRY: begin
                    if (retry_r < R_MAX) begin
                        retry_r    <= retry_r + {{(RW-1){1'b0}}, 1'b1};
                        i2c_req    <= 1'b1;
                        i2c_writes <= 1'b1;
                        i2c_reads  <= 4'd0;
                        state_r    <= CMD_REQ;
                    end else begin
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_measure_sequencer.sv
// Testbench for sht40_measure_sequencer. It includes an I2C master/SHT40 responder,
// a measurement-level outcome model, and directed and randomized measurements.
module tb_sht40_measure_sequencer;

    localparam int N    = 40;
    localparam int RMAX = 3;
    localparam int K_GOOD  = 0;
    localparam int K_CNACK = 1;
    localparam int K_RNACK = 2;
    localparam int K_SHORT = 3;
    localparam int K_EXTRA = 4;

    logic        clk, rst_n, start;
    logic        busy, done, error, crc_err, i2c_req, i2c_writes;
    logic [15:0] temp_raw, hum_raw;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_cmd, i2c_byte;
    logic [3:0]  i2c_reads;
    logic        i2c_byte_vld, i2c_done, i2c_nack;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, crc_cnt = 0, excl_bad = 0;

    int         kind_a [RMAX+1];
    logic [7:0] byt_a  [RMAX+1][6];
    bit         same_a [RMAX+1];
    bit         xst_a  [RMAX+1];
    logic [15:0] last_temp = 16'h0000;
    logic [15:0] last_hum  = 16'h0000;

    sht40_measure_sequencer #(.MEAS_WAIT_CYC(N), .RETRY_MAX(RMAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
        .temp_raw(temp_raw), .hum_raw(hum_raw), .crc_err(crc_err), .i2c_req(i2c_req),
        .i2c_addr(i2c_addr), .i2c_cmd(i2c_cmd), .i2c_writes(i2c_writes), .i2c_reads(i2c_reads),
        .i2c_byte_vld(i2c_byte_vld), .i2c_byte(i2c_byte), .i2c_done(i2c_done), .i2c_nack(i2c_nack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles, request pulses by phase, and result pulses. It also flags any overlap of result pulses.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (i2c_req && i2c_writes)  wr_cnt <= wr_cnt + 1;
        if (i2c_req && !i2c_writes) rd_cnt <= rd_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
        if (error)   err_cnt  <= err_cnt + 1;
        if (crc_err) crc_cnt  <= crc_cnt + 1;
        if (int'(done) + int'(error) + int'(crc_err) > 1) excl_bad <= excl_bad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC reference: polynomial long division of (word with 0xFF preloaded) * x^8 by x^8+x^5+x^4+1.
    function automatic logic [7:0] ref_crc(input logic [15:0] w);
        logic [23:0] r;
        r = {w ^ 16'hFF00, 8'h00};
        for (int i = 23; i >= 8; i--)
            if (r[i]) r = r ^ (24'h000131 << (i - 8));
        return r[7:0];
    endfunction

    function automatic bit good_crc(input int a);
`ifdef SHT40_CRC_CHECK_EN
        return (ref_crc({byt_a[a][0], byt_a[a][1]}) == byt_a[a][2]) &&
               (ref_crc({byt_a[a][3], byt_a[a][4]}) == byt_a[a][5]);
`else
        return 1'b1;
`endif
    endfunction

    task automatic set_att(input int a, input int k, input logic [15:0] t, input logic [15:0] h);
        kind_a[a] = k;
        byt_a[a][0] = t[15:8]; byt_a[a][1] = t[7:0]; byt_a[a][2] = ref_crc(t);
        byt_a[a][3] = h[15:8]; byt_a[a][4] = h[7:0]; byt_a[a][5] = ref_crc(h);
        same_a[a] = 1'b0; xst_a[a] = 1'b0;
    endtask

    task automatic wait_req(output int at);
        int k;
        k = 0;
        while (i2c_req !== 1'b1 && k < N + 60) begin
            @(negedge clk);
            k++;
        end
        if (i2c_req !== 1'b1) chk("req_timeout", 32'd0, 32'd1);
        at = cyc;
    endtask

    task automatic serve(input int a);
        int t0, t1, nb;
        wait_req(t0);
        chk("wr_phase", {27'd0, i2c_writes, i2c_reads}, {27'd0, 1'b1, 4'd0});
        chk("busy_run", {31'd0, busy}, 32'd1);
        @(negedge clk); start = xst_a[a];
        @(negedge clk); start = 1'b0;
        if (kind_a[a] == K_CNACK) begin
            i2c_nack = 1'b1; @(negedge clk); i2c_nack = 1'b0;
            return;
        end
        i2c_done = 1'b1; t0 = cyc; @(negedge clk); i2c_done = 1'b0;
        wait_req(t1);
        chk("rd_phase", {27'd0, i2c_writes, i2c_reads}, {27'd0, 1'b0, 4'd6});
        chk("conv_lat", t1 - t0, N + 1);
        @(negedge clk);
        nb = (kind_a[a] == K_SHORT) ? 4 : (kind_a[a] == K_RNACK) ? 2 : (kind_a[a] == K_EXTRA) ? 7 : 6;
        for (int i = 0; i < nb; i++) begin
            i2c_byte_vld = 1'b1;
            i2c_byte = (i < 6) ? byt_a[a][i] : 8'($urandom);
            if (i == nb - 1 && kind_a[a] != K_RNACK && same_a[a]) i2c_done = 1'b1;
            @(negedge clk); i2c_byte_vld = 1'b0; i2c_done = 1'b0;
            @(negedge clk);
        end
        if (kind_a[a] == K_RNACK) begin
            i2c_nack = 1'b1; @(negedge clk); i2c_nack = 1'b0;
        end else if (!same_a[a]) begin
            i2c_done = 1'b1; @(negedge clk); i2c_done = 1'b0;
        end
    endtask

    // Runs one measurement. The model predicts the attempts, the outcome, and the published words.
    task automatic run_meas(input string tag);
        int n_att, n_rd, n_crc, succ, w0, r0, d0, e0, c0, k;
        bit ok;
        logic [15:0] et, eh;
        n_att = 0; n_rd = 0; n_crc = 0; ok = 1'b0; succ = 0;
        for (int a = 0; a <= RMAX; a++) begin
            n_att = a + 1;
            if (kind_a[a] != K_CNACK) n_rd++;
            if (kind_a[a] == K_GOOD || kind_a[a] == K_EXTRA) begin
                if (good_crc(a)) begin ok = 1'b1; succ = a; break; end
                else n_crc++;
            end
        end
        et = ok ? {byt_a[succ][0], byt_a[succ][1]} : last_temp;
        eh = ok ? {byt_a[succ][3], byt_a[succ][4]} : last_hum;
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; e0 = err_cnt; c0 = crc_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int a = 0; a < n_att; a++) serve(a);
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done"},  done_cnt - d0, ok ? 1 : 0);
        chk({tag, "_error"}, err_cnt - e0,  ok ? 0 : 1);
        chk({tag, "_temp"},  {16'd0, temp_raw}, {16'd0, et});
        chk({tag, "_hum"},   {16'd0, hum_raw},  {16'd0, eh});
        chk({tag, "_wrreq"}, wr_cnt - w0, n_att);
        chk({tag, "_rdreq"}, rd_cnt - r0, n_rd);
        chk({tag, "_crcerr"}, crc_cnt - c0, n_crc);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);
        chk({tag, "_noextra"}, wr_cnt - w0, n_att);
        last_temp = et; last_hum = eh;
    endtask

    initial begin
        int t0;
        logic [15:0] t, h;
        rst_n = 1'b0; start = 1'b0; i2c_byte_vld = 1'b0; i2c_byte = 8'h00;
        i2c_done = 1'b0; i2c_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pulses", {29'd0, done, error, crc_err}, 32'd0);
        chk("rst_req", {27'd0, i2c_req, i2c_reads}, 32'd0);
        chk("rst_writes", {31'd0, i2c_writes}, 32'd0);
        chk("rst_data", {temp_raw, hum_raw}, 32'd0);
        chk("rst_addr", {25'd0, i2c_addr}, 32'h44);
        chk("rst_cmd", {24'd0, i2c_cmd}, 32'hFD);
        rst_n = 1'b1;
        @(negedge clk);

        // Datasheet example: 0xBEEF/0x92 and 0x6666/0x93. The last byte arrives together with done.
        for (int a = 0; a <= RMAX; a++) set_att(a, K_GOOD, 16'hBEEF, 16'h6666);
        same_a[0] = 1'b1;
        run_meas("golden");
        chk("golden_temp_lit", {16'd0, temp_raw}, 32'hBEEF);
        chk("golden_hum_lit",  {16'd0, hum_raw},  32'h6666);

        // The temperature CRC is corrupted on the first attempt. The retry is clean.
        for (int a = 0; a <= RMAX; a++) set_att(a, K_GOOD, 16'h1234, 16'h5678);
        byt_a[0][2] = 8'h00;
        run_meas("crcbad");

        // The command is NACKed on every attempt.
        for (int a = 0; a <= RMAX; a++) set_att(a, K_CNACK, 16'hAAAA, 16'h5555);
        run_meas("allnack");

        // The first attempt is a short read with start pulsed while busy. The second returns an extra byte.
        for (int a = 0; a <= RMAX; a++) set_att(a, K_GOOD, 16'h0F0F, 16'hF00D);
        kind_a[0] = K_SHORT; xst_a[0] = 1'b1; kind_a[1] = K_EXTRA;
        run_meas("short");

        // Reset is applied during conversion, then one clean measurement follows.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_req(t0);
        @(negedge clk); i2c_done = 1'b1;
        @(negedge clk); i2c_done = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstconv_busy", {31'd0, busy}, 32'd0);
        chk("rstconv_req", {31'd0, i2c_req}, 32'd0);
        chk("rstconv_data", {temp_raw, hum_raw}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        last_temp = 16'h0000; last_hum = 16'h0000;
        for (int a = 0; a <= RMAX; a++) set_att(a, K_GOOD, 16'h6502, 16'h7A1C);
        run_meas("afterrst");

        // Randomized attempt sequences.
        for (int n = 0; n < 6; n++) begin
            for (int a = 0; a <= RMAX; a++) begin
                t = 16'($urandom); h = 16'($urandom);
                case ($urandom_range(0, 5))
                    0, 1:    set_att(a, K_GOOD,  t, h);
                    2:       set_att(a, K_CNACK, t, h);
                    3:       set_att(a, K_RNACK, t, h);
                    4:       set_att(a, K_SHORT, t, h);
                    default: set_att(a, K_EXTRA, t, h);
                endcase
                if ($urandom_range(0, 9) < 3) byt_a[a][5] = byt_a[a][5] ^ 8'(1 + $urandom_range(0, 254));
                same_a[a] = 1'($urandom);
                xst_a[a]  = 1'($urandom);
            end
            run_meas("rand");
        end

        chk("pulse_exclusive", excl_bad, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
